voice_bank_seq: RTL and testbench

//  Next-generation polyphonic note register bank: N addressable voice slots, each holding a

---
 rtl/voice_bank_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_voice_bank_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_bank_seq.sv
// ---------------------------------------------------------------------------
// voice_bank_seq
//
// Polyphonic note register bank. NUM_CHANNELS voice slots each hold a signed
// note sample, an unsigned velocity gain and an active flag. A sample_tick
// starts a time-multiplexed mix: one slot is read per clock, scaled by
// vel / 2^NUM_BITS_VEL (floor), and accumulated. The final sum is saturated
// to the output width and presented on note_out with a one-cycle note_valid.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   wr_en        write note_in/vel_in into slot wr_ch and mark it active
//   wr_ch        slot index for write (out-of-range indices are ignored)
//   note_in      signed note sample
//   vel_in       unsigned velocity
//   clr_en       deactivate slot clr_ch (a same-slot write takes precedence)
//   clr_ch       slot index for clear (out-of-range indices are ignored)
//   sample_tick  one-cycle request for a mixed sample
//   note_out     signed mixed sample, held until the next result
//   note_valid   one-cycle pulse when note_out updates
//   active       per-slot active flags
//   busy         high while a mix is in progress
//   overrun      one-cycle pulse: sample_tick arrived while busy
//
// Timing: tick in cycle t -> slot i read in cycle t+1+i -> result and
// note_valid in cycle t+N+2, the same cycle busy drops.
// ---------------------------------------------------------------------------
module voice_bank_seq #(
  parameter  int NUM_BITS_IN  = 18,
  parameter  int NUM_BITS_OUT = 24,
  parameter  int NUM_BITS_VEL = 7,
  parameter  int NUM_CHANNELS = 16,
  localparam int CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CH_BITS-1:0]      wr_ch,
  input  logic [NUM_BITS_IN-1:0]  note_in,
  input  logic [NUM_BITS_VEL-1:0] vel_in,
  input  logic                    clr_en,
  input  logic [CH_BITS-1:0]      clr_ch,
  input  logic                    sample_tick,
  output logic [NUM_BITS_OUT-1:0] note_out,
  output logic                    note_valid,
  output logic [NUM_CHANNELS-1:0] active,
  output logic                    busy,
  output logic                    overrun
);

  // Accumulator is wide enough for N full-scale products, so it never wraps.
  localparam int ACC_W  = NUM_BITS_IN + CH_BITS + 1;
  localparam int PROD_W = NUM_BITS_IN + NUM_BITS_VEL + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [CH_BITS-1:0] LAST_IDX = CH_BITS'(NUM_CHANNELS - 1);

  // -------------------------------------------------------------------------
  // Slot storage
  // -------------------------------------------------------------------------
  logic signed [NUM_BITS_IN-1:0]  note_mem [NUM_CHANNELS];
  logic        [NUM_BITS_VEL-1:0] vel_mem  [NUM_CHANNELS];
  logic        [NUM_CHANNELS-1:0] active_q;
  logic        [NUM_CHANNELS-1:0] wr_hit;
  logic        [NUM_CHANNELS-1:0] clr_hit;

  // One-hot decode of the write/clear targets. An index >= NUM_CHANNELS
  // matches no slot, which is how out-of-range requests are dropped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    wr_hit  = '0;
    clr_hit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      wr_hit[i]  = wr_en  && (wr_ch  == CH_BITS'(i));
      clr_hit[i] = clr_en && (clr_ch == CH_BITS'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the slot arrays are reset explicitly because a freshly reset
      // bank must mix to zero; this makes them flops rather than a RAM.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        note_mem[i] <= '0;
        vel_mem[i]  <= '0;
      end
      active_q <= '0;
    end else begin
      // NOTE: sequential state is assigned with <= only, so every flop
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_hit[i]) begin
          note_mem[i] <= note_in;
          vel_mem[i]  <= vel_in;
          active_q[i] <= 1'b1;
        end else if (clr_hit[i]) begin
          active_q[i] <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Mix datapath
  // -------------------------------------------------------------------------
  logic        [1:0]              state;
  logic        [CH_BITS-1:0]      idx;
  logic signed [ACC_W-1:0]        acc;
  logic signed [NUM_BITS_IN-1:0]  prod_q;
  logic                           prod_vld;
  logic signed [NUM_BITS_OUT-1:0] note_out_q;

  logic signed [NUM_BITS_IN-1:0]  rd_note;
  logic        [NUM_BITS_VEL-1:0] rd_vel;
  logic                           rd_act;
  logic signed [PROD_W-1:0]       prod_full;
  logic signed [PROD_W-1:0]       prod_sh;
  logic signed [NUM_BITS_IN-1:0]  prod_d;
  logic signed [ACC_W-1:0]        sum_next;
  logic signed [NUM_BITS_OUT-1:0] out_d;

  // Slot values are taken live in the cycle they are read; a write that
  // lands before the read is seen, one that lands after is not.
  assign rd_note = note_mem[idx];
  assign rd_vel  = vel_mem[idx];
  assign rd_act  = active_q[idx];

  // Velocity is zero-extended to a positive signed operand, so the product
  // carries the note's sign; >>> then floors toward -inf.
  assign prod_full = rd_note * $signed({1'b0, rd_vel});
  assign prod_sh   = prod_full >>> NUM_BITS_VEL;
  // |vel / 2^VEL| < 1, so the scaled product always fits the note width.
  assign prod_d    = rd_act ? NUM_BITS_IN'(prod_sh) : '0;

  assign sum_next  = acc + ACC_W'(prod_q);

  generate
    if (ACC_W <= NUM_BITS_OUT) begin : g_extend
      assign out_d = NUM_BITS_OUT'(sum_next);
    end else begin : g_saturate
      localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - NUM_BITS_OUT + 1){1'b0}}, {(NUM_BITS_OUT - 1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - NUM_BITS_OUT + 1){1'b1}}, {(NUM_BITS_OUT - 1){1'b0}}};
      always_comb begin
        out_d = NUM_BITS_OUT'(sum_next);
        if (sum_next > SAT_MAX) begin
          out_d = NUM_BITS_OUT'(SAT_MAX);
        end else if (sum_next < SAT_MIN) begin
          out_d = NUM_BITS_OUT'(SAT_MIN);
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sequencer
  //   IDLE  : wait for sample_tick, clear acc
  //   ACCUM : read slot idx (product registered), add previous product
  //   FLUSH : add last product, write note_out
  // prod_vld marks that prod_q holds a product from the previous read cycle,
  // which is false in the first ACCUM cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      prod_q     <= '0;
      prod_vld   <= 1'b0;
      note_out_q <= '0;
      note_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      overrun    <= sample_tick && (state != IDLE);
      prod_q     <= prod_d;
      prod_vld   <= (state == ACCUM);

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ACCUM;
            idx   <= '0;
            acc   <= '0;
          end
        end
        ACCUM: begin
          if (prod_vld) begin
            acc <= sum_next;
          end
          if (idx == LAST_IDX) begin
            state <= FLUSH;
          end else begin
            idx <= idx + CH_BITS'(1);
          end
        end
        FLUSH: begin
          note_out_q <= out_d;
          note_valid <= 1'b1;
          idx        <= '0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign note_out = note_out_q;
  assign active   = active_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_voice_bank_seq.sv
// ---------------------------------------------------------------------------
// tb_voice_bank_seq
//
// Drives two instances from the same stimulus: dut_a with the default 24-bit
// output (no saturation possible) and dut_b with an 18-bit output (saturates).
// A behavioural slot model computes each expected mix when a tick is issued;
// the results are queued and popped by a monitor whenever note_valid pulses.
// ---------------------------------------------------------------------------
module tb_voice_bank_seq;

  localparam int N     = 16;
  localparam int IN_W  = 18;
  localparam int VEL_W = 7;
  localparam int OUT_A = 24;
  localparam int OUT_B = 18;
  localparam int LAT   = N + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [IN_W-1:0]  note_in;
  logic [VEL_W-1:0] vel_in;
  logic             clr_en;
  logic [3:0]       clr_ch;
  logic             sample_tick;

  logic [OUT_A-1:0] note_out_a;
  logic [OUT_B-1:0] note_out_b;
  logic             note_valid_a, note_valid_b;
  logic [N-1:0]     active_a, active_b;
  logic             busy_a, busy_b;
  logic             overrun_a, overrun_b;

  int tests_run = 0;
  int tests_failed = 0;

  longint m_note [N];
  longint m_vel  [N];
  bit     m_act  [N];
  longint exp_a [$];
  longint exp_b [$];

  always #5 clk = ~clk;

  voice_bank_seq dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .note_in(note_in),
    .vel_in(vel_in), .clr_en(clr_en), .clr_ch(clr_ch), .sample_tick(sample_tick),
    .note_out(note_out_a), .note_valid(note_valid_a), .active(active_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  voice_bank_seq #(.NUM_BITS_OUT(OUT_B)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .note_in(note_in),
    .vel_in(vel_in), .clr_en(clr_en), .clr_ch(clr_ch), .sample_tick(sample_tick),
    .note_out(note_out_b), .note_valid(note_valid_b), .active(active_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  // ---------------- model ----------------
  function automatic longint model_mix(input int out_w);
    longint s, hi, lo;
    s = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) s += (m_note[i] * m_vel[i]) >>> VEL_W;
    end
    hi = (longint'(1) << (out_w - 1)) - 1;
    lo = -(longint'(1) << (out_w - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_note[i] = 0;
      m_vel[i]  = 0;
      m_act[i]  = 1'b0;
    end
  endfunction

  function automatic void push_expected();
    exp_a.push_back(model_mix(OUT_A));
    exp_b.push_back(model_mix(OUT_B));
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    longint e;
    if (note_valid_a === 1'b1) begin
      tests_run++;
      if (exp_a.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_a_unexpected: got note_valid with value %0d, expected no result",
                 longint'($signed(note_out_a)));
      end else begin
        e = exp_a.pop_front();
        if (longint'($signed(note_out_a)) !== e) begin
          tests_failed++;
          $display("FAIL sb_a_value: got %0d expected %0d", longint'($signed(note_out_a)), e);
        end
      end
    end
    if (note_valid_b === 1'b1) begin
      tests_run++;
      if (exp_b.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_b_unexpected: got note_valid with value %0d, expected no result",
                 longint'($signed(note_out_b)));
      end else begin
        e = exp_b.pop_front();
        if (longint'($signed(note_out_b)) !== e) begin
          tests_failed++;
          $display("FAIL sb_b_value: got %0d expected %0d", longint'($signed(note_out_b)), e);
        end
      end
    end
  end

  // ---------------- stimulus helpers (all start and end at a negedge) ----
  task automatic write_slot(input int ch, input int note, input int vel);
    wr_en = 1'b1; wr_ch = 4'(ch); note_in = IN_W'(note); vel_in = VEL_W'(vel);
    m_note[ch] = note; m_vel[ch] = vel; m_act[ch] = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_slot(input int ch);
    clr_en = 1'b1; clr_ch = 4'(ch);
    m_act[ch] = 1'b0;
    @(negedge clk);
    clr_en = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  // Issue a tick, optionally write one slot two cycles later (mid-sum), and
  // wait for the result. upd_before: the model sees the write before the
  // expected value is taken (slot read after the write).
  task automatic tick_with_write(input string name, input bit do_wr, input int ch,
                                 input int note, input int vel, input bit upd_before);
    int lat;
    if (do_wr && upd_before) begin
      m_note[ch] = note; m_vel[ch] = vel; m_act[ch] = 1'b1;
    end
    sample_tick = 1'b1;
    push_expected();
    if (do_wr && !upd_before) begin
      m_note[ch] = note; m_vel[ch] = vel; m_act[ch] = 1'b1;
    end
    lat = 0;
    while (lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
      sample_tick = 1'b0;
      wr_en = 1'b0;
      if (do_wr && lat == 2) begin
        wr_en = 1'b1; wr_ch = 4'(ch); note_in = IN_W'(note); vel_in = VEL_W'(vel);
      end
      if (note_valid_a === 1'b1) break;
    end
    wr_en = 1'b0;
    tests_run++;
    if (lat != LAT) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, LAT);
    end
    tests_run++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_busy_drop: got busy %b/%b expected 0/0", name, busy_a, busy_b);
    end
  endtask

  task automatic run_tick(input string name);
    tick_with_write(name, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_out_a(input string name, input longint expv);
    tests_run++;
    if (longint'($signed(note_out_a)) !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, longint'($signed(note_out_a)), expv);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (note_out_a !== '0 || note_out_b !== '0 || note_valid_a !== 1'b0 ||
        active_a !== '0 || busy_a !== 1'b0 || overrun_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got out=%0h valid=%b active=%h busy=%b ovr=%b expected all 0",
               note_out_a, note_valid_a, active_a, busy_a, overrun_a);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b0 || active_a !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: got busy=%b active=%h expected 0/0", busy_a, active_a);
    end
  endtask

  task automatic test_basic_mix();
    write_slot(0, 1000, 64);
    write_slot(3, -2000, 127);
    tests_run++;
    if (active_a !== 16'h0009) begin
      tests_failed++;
      $display("FAIL basic_active: got %h expected 0009", active_a);
    end
    run_tick("basic");
    check_out_a("basic_value", -1485);
  endtask

  task automatic test_clear_precedence();
    clear_slot(3);
    run_tick("clear");
    check_out_a("clear_value", 500);
    // same-cycle write and clear to slot 5: write wins
    wr_en = 1'b1; wr_ch = 4'd5; note_in = IN_W'(256); vel_in = VEL_W'(127);
    clr_en = 1'b1; clr_ch = 4'd5;
    m_note[5] = 256; m_vel[5] = 127; m_act[5] = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clr_en = 1'b0;
    tests_run++;
    if (active_a[5] !== 1'b1) begin
      tests_failed++;
      $display("FAIL precedence_active: got %b expected 1", active_a[5]);
    end
    run_tick("precedence");
    check_out_a("precedence_value", 754);
  endtask

  task automatic test_mid_reset();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (note_out_a !== '0 || note_out_b !== '0 || active_a !== '0 ||
        busy_a !== 1'b0 || busy_b !== 1'b0 || note_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got out=%0h/%0h active=%h busy=%b/%b valid=%b expected zeros",
               note_out_a, note_out_b, active_a, busy_a, busy_b, note_valid_a);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (LAT + 6) @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_idle: got busy %b expected 0", busy_a);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N; i++) write_slot(i, 131071, 127);
    run_tick("sat_pos");
    check_out_a("sat_pos_wide", 2080752);
    tests_run++;
    if (note_out_b !== 18'h1FFFF) begin
      tests_failed++;
      $display("FAIL sat_pos_narrow: got %0d expected 131071", $signed(note_out_b));
    end
    for (int i = 0; i < N; i++) write_slot(i, -131072, 127);
    run_tick("sat_neg");
    check_out_a("sat_neg_wide", -2080768);
    tests_run++;
    if (note_out_b !== 18'h20000) begin
      tests_failed++;
      $display("FAIL sat_neg_narrow: got %0d expected -131072", $signed(note_out_b));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    sample_tick = 1'b1;
    push_expected();
    lat = 0;
    while (lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
      sample_tick = 1'b0;
      if (lat == 5) begin
        tests_run++;
        if (overrun_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL overrun_pre: got %b expected 0", overrun_a);
        end
        sample_tick = 1'b1;
      end
      if (lat == 6) begin
        tests_run++;
        if (overrun_a !== 1'b1 || overrun_b !== 1'b1) begin
          tests_failed++;
          $display("FAIL overrun_pulse: got %b/%b expected 1/1", overrun_a, overrun_b);
        end
      end
      if (lat == 7) begin
        tests_run++;
        if (overrun_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL overrun_width: got %b expected 0", overrun_a);
        end
      end
      if (note_valid_a === 1'b1) break;
    end
    tests_run++;
    if (lat != LAT) begin
      tests_failed++;
      $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT);
    end
    // tick in the result cycle is accepted
    run_tick("b2b_second");
  endtask

  task automatic test_mid_sum_write();
    reset_dut();
    write_slot(0, 1000, 64);
    // slot 15 is read late: the mid-sum write is included
    tick_with_write("midwr_ch15", 1'b1, 15, 100, 127, 1'b1);
    check_out_a("midwr_ch15_value", 599);
    // slot 0 is read first: the mid-sum write is excluded this time
    tick_with_write("midwr_ch0", 1'b1, 0, 100, 127, 1'b0);
    check_out_a("midwr_ch0_value", 599);
    run_tick("midwr_after");
    check_out_a("midwr_after_value", 198);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; note_in = '0; vel_in = '0;
    clr_en = 1'b0; clr_ch = '0; sample_tick = 1'b0;
    model_clear();
    test_reset();
    test_basic_mix();
    test_clear_precedence();
    test_mid_reset();
    test_saturation();
    test_back_to_back();
    test_mid_sum_write();
    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d/%0d pending results expected 0/0",
               exp_a.size(), exp_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
